// File: rtl/mux2_stream_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mux2_stream_arbiter_pkg
// Shared types and constants for the two-input round-robin stream arbiter.
//   state_e     : arbiter state (free to arbitrate, or locked to one stream)
//   GRANT_RESET : grant value driven while reset is asserted
// -----------------------------------------------------------------------------
package mux2_stream_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOCK0 = 2'b01,
        ST_LOCK1 = 2'b10
    } state_e;

    localparam logic GRANT_RESET = 1'b0;

endpackage

// File: rtl/mux2_stream_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux2_stream_arbiter_if
// Bundles the two input streams, the output stream and the grant of the
// arbiter.
//
// Handshake: a beat moves on a stream in the cycle where valid and ready are
// both high at the rising clock edge. A source raises valid independently of
// ready and keeps valid, data and last stable until that edge; the arbiter
// may raise or drop ready at any time.
//
//   master : upstream sources plus downstream sink (drives stream inputs and
//            OutReady_SI, observes readies, output stream and grant)
//   slave  : arbiter side
// -----------------------------------------------------------------------------
interface mux2_stream_arbiter_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] In0_DI;
    logic             In0Valid_SI;
    logic             In0Last_SI;
    logic             In0Ready_SO;
    logic [WIDTH-1:0] In1_DI;
    logic             In1Valid_SI;
    logic             In1Last_SI;
    logic             In1Ready_SO;
    logic [WIDTH-1:0] Out_DO;
    logic             OutValid_SO;
    logic             OutLast_SO;
    logic             OutReady_SI;
    logic             Sel_SO;

    modport master (
        output In0_DI, In0Valid_SI, In0Last_SI,
        output In1_DI, In1Valid_SI, In1Last_SI,
        output OutReady_SI,
        input  In0Ready_SO, In1Ready_SO,
        input  Out_DO, OutValid_SO, OutLast_SO, Sel_SO
    );

    modport slave (
        input  In0_DI, In0Valid_SI, In0Last_SI,
        input  In1_DI, In1Valid_SI, In1Last_SI,
        input  OutReady_SI,
        output In0Ready_SO, In1Ready_SO,
        output Out_DO, OutValid_SO, OutLast_SO, Sel_SO
    );

endinterface

// File: rtl/mux2_stream_arbiter_mux2.sv
// -----------------------------------------------------------------------------
// mux2_stream_arbiter_mux2
// Plain 2:1 data multiplexer used on the arbiter's data path.
//   In0_DI  : selected when Sel_SI = 0
//   In1_DI  : selected when Sel_SI = 1
//   Sel_SI  : select
//   Out_DO  : selected data (combinational)
// -----------------------------------------------------------------------------
module mux2_stream_arbiter_mux2 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] In0_DI,
    input  logic [WIDTH-1:0] In1_DI,
    input  logic             Sel_SI,
    output logic [WIDTH-1:0] Out_DO
);

    assign Out_DO = Sel_SI ? In1_DI : In0_DI;

endmodule

// File: rtl/mux2_stream_arbiter.sv
// -----------------------------------------------------------------------------
// mux2_stream_arbiter
// Two-input round-robin stream arbiter with packet lock. Once the first beat
// of a multi-beat packet is accepted the grant stays on that stream until its
// last beat is accepted; single-beat packets never lock. Between packets the
// grant goes to the only valid stream, or to the priority pointer, which
// points away from the stream that finished the most recent packet.
// The selected beat is registered into a single output stage.
//
// Ports:
//   Clk_CI, Rst_RI            : clock (rising edge), async active-high reset
//   In0_* / In1_*             : input streams (data, valid, last, ready)
//   Out_DO/OutValid_SO/OutLast_SO, OutReady_SI : registered output stream
//   Sel_SO                    : current grant, combinational
// -----------------------------------------------------------------------------
module mux2_stream_arbiter
    import mux2_stream_arbiter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clk_CI,
    input  logic             Rst_RI,
    input  logic [WIDTH-1:0] In0_DI,
    input  logic             In0Valid_SI,
    input  logic             In0Last_SI,
    output logic             In0Ready_SO,
    input  logic [WIDTH-1:0] In1_DI,
    input  logic             In1Valid_SI,
    input  logic             In1Last_SI,
    output logic             In1Ready_SO,
    output logic [WIDTH-1:0] Out_DO,
    output logic             OutValid_SO,
    output logic             OutLast_SO,
    input  logic             OutReady_SI,
    output logic             Sel_SO
);

    state_e           state_q, state_d;
    logic             prio_q, prio_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             sel;
    logic             free;
    logic             sel_valid;
    logic             sel_last;
    logic             acc;
    logic [WIDTH-1:0] mux_data;

    // Grant. Illegal state encodings fall into the default arm and behave
    // as IDLE.
    always_comb begin
        sel = prio_q;
        case (state_q)
            ST_LOCK0: sel = 1'b0;
            ST_LOCK1: sel = 1'b1;
            default: begin
                if (In0Valid_SI != In1Valid_SI) begin
                    sel = In1Valid_SI;
                end else begin
                    sel = prio_q;
                end
            end
        endcase
        if (Rst_RI) begin
            sel = GRANT_RESET;
        end
    end

    // Output stage can take a new beat when empty or being drained.
    assign free      = ~out_valid_q | OutReady_SI;
    assign sel_valid = sel ? In1Valid_SI : In0Valid_SI;
    assign sel_last  = sel ? In1Last_SI : In0Last_SI;
    assign acc       = free & sel_valid & ~Rst_RI;

    assign In0Ready_SO = free & ~sel & ~Rst_RI;
    assign In1Ready_SO = free & sel & ~Rst_RI;
    assign Sel_SO      = sel;

    mux2_stream_arbiter_mux2 #(
        .WIDTH (WIDTH)
    ) u_mux2 (
        .In0_DI (In0_DI),
        .In1_DI (In1_DI),
        .Sel_SI (sel),
        .Out_DO (mux_data)
    );

    // Next state and output stage.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;

        if (acc) begin
            out_data_d  = mux_data;
            out_last_d  = sel_last;
            out_valid_d = 1'b1;
            case (state_q)
                ST_LOCK0, ST_LOCK1: begin
                    // While locked, sel equals the locked stream.
                    if (sel_last) begin
                        state_d = ST_IDLE;
                        prio_d  = ~sel;
                    end
                end
                default: begin
                    if (sel_last) begin
                        state_d = ST_IDLE;
                        prio_d  = ~sel;
                    end else begin
                        state_d = sel ? ST_LOCK1 : ST_LOCK0;
                    end
                end
            endcase
        end else if (free) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            state_q     <= ST_IDLE;
            prio_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign Out_DO      = out_data_q;
    assign OutValid_SO = out_valid_q;
    assign OutLast_SO  = out_last_q;

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux2_stream_arbiter
// Directed scenarios followed by randomized traffic. A behavioural model of
// the arbiter (lock owner, priority pointer, one output register) plus an
// expected-beat queue is checked against the DUT every falling edge.
// -----------------------------------------------------------------------------
module tb_mux2_stream_arbiter;

    localparam int W = 16;

    typedef struct {
        int         gap;   // idle cycles after the previous beat of the stream
        logic       last;
        logic [W-1:0] data;
    } beat_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT and interface ----------------
    mux2_stream_arbiter_if #(.WIDTH(W)) bus ();

    logic         v[2];
    logic         l[2];
    logic [W-1:0] d[2];
    logic         out_ready;
    logic         rand_mode;

    assign bus.In0_DI      = d[0];
    assign bus.In0Valid_SI = v[0];
    assign bus.In0Last_SI  = l[0];
    assign bus.In1_DI      = d[1];
    assign bus.In1Valid_SI = v[1];
    assign bus.In1Last_SI  = l[1];
    assign bus.OutReady_SI = out_ready;

    mux2_stream_arbiter #(.WIDTH(W)) dut (
        .Clk_CI      (clk),
        .Rst_RI      (rst),
        .In0_DI      (bus.In0_DI),
        .In0Valid_SI (bus.In0Valid_SI),
        .In0Last_SI  (bus.In0Last_SI),
        .In0Ready_SO (bus.In0Ready_SO),
        .In1_DI      (bus.In1_DI),
        .In1Valid_SI (bus.In1Valid_SI),
        .In1Last_SI  (bus.In1Last_SI),
        .In1Ready_SO (bus.In1Ready_SO),
        .Out_DO      (bus.Out_DO),
        .OutValid_SO (bus.OutValid_SO),
        .OutLast_SO  (bus.OutLast_SO),
        .OutReady_SI (bus.OutReady_SI),
        .Sel_SO      (bus.Sel_SO)
    );

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    beat_t src0_q[$];
    beat_t src1_q[$];
    int    wait_cnt[2];
    logic  hs[2];

    logic [W:0]   exp_q[$];   // {last, data} of accepted beats, in order
    logic [W-1:0] out_log[$];
    int           out_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic push0(input int gap, input logic last, input logic [W-1:0] data);
        beat_t b;
        b.gap = gap; b.last = last; b.data = data;
        src0_q.push_back(b);
    endtask

    task automatic push1(input int gap, input logic last, input logic [W-1:0] data);
        beat_t b;
        b.gap = gap; b.last = last; b.data = data;
        src1_q.push_back(b);
    endtask

    // ---------------- driver ----------------
    // Runs 1 time unit after each rising edge; hs[] was sampled on the
    // preceding falling edge, so it reflects the handshake at this edge.
    always @(posedge clk) begin : driver_p
        beat_t b;
        #1;
        if (hs[0]) begin
            v[0] = 1'b0;
            if (src0_q.size() > 0) wait_cnt[0] = src0_q[0].gap;
        end
        if (!v[0] && src0_q.size() > 0) begin
            if (wait_cnt[0] > 0) begin
                wait_cnt[0]--;
            end else begin
                b = src0_q.pop_front();
                d[0] = b.data; l[0] = b.last; v[0] = 1'b1;
            end
        end
        if (hs[1]) begin
            v[1] = 1'b0;
            if (src1_q.size() > 0) wait_cnt[1] = src1_q[0].gap;
        end
        if (!v[1] && src1_q.size() > 0) begin
            if (wait_cnt[1] > 0) begin
                wait_cnt[1]--;
            end else begin
                b = src1_q.pop_front();
                d[1] = b.data; l[1] = b.last; v[1] = 1'b1;
            end
        end
        if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    end

    // ---------------- model + compare ----------------
    int           m_lock;   // -1: not locked, else locked stream
    logic         m_prio;
    logic         m_valid;
    logic         m_last;
    logic [W-1:0] m_data;

    logic         p_v[2];
    logic         p_l[2];
    logic [W-1:0] p_d[2];
    logic         p_hs[2];

    always @(negedge clk) begin : compare_p
        logic         g;
        logic         fr;
        logic         acc;
        logic [W:0]   e;
        cycle++;
        // Source-side protocol: a pending beat must not change.
        for (int x = 0; x < 2; x++) begin
            if (p_v[x] && !p_hs[x] && (!v[x] || l[x] !== p_l[x] || d[x] !== p_d[x]))
                $error("source %0d changed a pending beat", x);
        end
        if (rst) begin
            m_lock = -1; m_prio = 1'b0; m_valid = 1'b0; m_last = 1'b0; m_data = '0;
            exp_q.delete();
            chk("rst_ready0", bus.In0Ready_SO, 0);
            chk("rst_ready1", bus.In1Ready_SO, 0);
            chk("rst_out_valid", bus.OutValid_SO, 0);
            chk("rst_out_data", bus.Out_DO, 0);
            chk("rst_sel", bus.Sel_SO, 0);
            hs[0] = 1'b0; hs[1] = 1'b0;
        end else begin
            if (m_lock >= 0)           g = m_lock[0];
            else if (v[0] && !v[1])    g = 1'b0;
            else if (v[1] && !v[0])    g = 1'b1;
            else                       g = m_prio;
            fr  = !m_valid || out_ready;
            acc = fr && v[g];

            chk("sel", bus.Sel_SO, g);
            chk("ready0", bus.In0Ready_SO, fr && !g);
            chk("ready1", bus.In1Ready_SO, fr && g);
            chk("out_valid", bus.OutValid_SO, m_valid);
            chk("out_data", bus.Out_DO, m_data);
            chk("out_last", bus.OutLast_SO, m_last);

            if (bus.OutValid_SO && out_ready) begin
                out_log.push_back(bus.Out_DO);
                out_cyc.push_back(cycle);
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_beat", {bus.OutLast_SO, bus.Out_DO}, e);
                end
            end

            hs[0] = v[0] && bus.In0Ready_SO;
            hs[1] = v[1] && bus.In1Ready_SO;

            if (acc) begin
                exp_q.push_back({l[g], d[g]});
                m_data = d[g]; m_last = l[g]; m_valid = 1'b1;
                if (m_lock < 0) begin
                    if (l[g]) m_prio = ~g;
                    else      m_lock = int'(g);
                end else if (l[g]) begin
                    m_lock = -1;
                    m_prio = ~g;
                end
            end else if (fr) begin
                m_valid = 1'b0;
            end
        end
        for (int x = 0; x < 2; x++) begin
            p_v[x] = v[x]; p_l[x] = l[x]; p_d[x] = d[x]; p_hs[x] = hs[x];
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (!(src0_q.size() == 0 && src1_q.size() == 0 && !v[0] && !v[1] &&
                 exp_q.size() == 0 && bus.OutValid_SO == 1'b0) && n < max_cycles) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= max_cycles) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: traffic still pending after %0d cycles", max_cycles);
        end
    endtask

    task automatic clear_log();
        out_log.delete();
        out_cyc.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin : main_p
        logic [W-1:0] held_data;
        logic         held_last;
        logic [W-1:0] e4[4];
        logic [W-1:0] e3[3];
        int           n;

        v[0] = 1'b0; v[1] = 1'b0; l[0] = 1'b0; l[1] = 1'b0; d[0] = '0; d[1] = '0;
        hs[0] = 1'b0; hs[1] = 1'b0; wait_cnt[0] = 0; wait_cnt[1] = 0;
        p_v[0] = 1'b0; p_v[1] = 1'b0; p_hs[0] = 1'b0; p_hs[1] = 1'b0;
        p_l[0] = 1'b0; p_l[1] = 1'b0; p_d[0] = '0; p_d[1] = '0;
        out_ready = 1'b1; rand_mode = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // --- async reset with a beat pending, then first beat after release
        @(posedge clk); #2;
        push0(0, 1'b1, 16'h1234);
        push0(0, 1'b1, 16'h00A5);
        @(posedge clk);
        @(posedge clk);      // 1234 accepted here, 00A5 presented at +1
        #3 rst = 1'b1;
        #1;
        chk("t1_async_out_valid", bus.OutValid_SO, 0);
        chk("t1_async_out_data", bus.Out_DO, 0);
        chk("t1_async_sel", bus.Sel_SO, 0);
        chk("t1_async_ready0", bus.In0Ready_SO, 0);
        chk("t1_async_ready1", bus.In1Ready_SO, 0);
        chk("t1_in0_valid_held", bus.In0Valid_SI, 1);
        @(posedge clk);
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("t1_first_data", bus.Out_DO, 16'h00A5);
        chk("t1_first_valid", bus.OutValid_SO, 1);
        chk("t1_first_last", bus.OutLast_SO, 1);
        wait_idle(50);

        // --- round robin: stream 0 went last, so stream 1 leads
        clear_log();
        for (int i = 0; i < 6; i++) begin
            push0(0, 1'b1, 16'h1111);
            push1(0, 1'b1, 16'h2222);
        end
        wait_idle(100);
        chk("t2_count", out_log.size(), 12);
        for (int i = 0; i < 12 && i < out_log.size(); i++) begin
            chk("t2_alternate", out_log[i], (i % 2 == 0) ? 16'h2222 : 16'h1111);
            chk("t2_one_per_cycle", out_cyc[i], out_cyc[0] + i);
        end

        // --- packet lock: stream 0 three-beat packet, stream 1 waits
        clear_log();
        push0(0, 1'b0, 16'hA001);
        push0(0, 1'b0, 16'hA002);
        push0(0, 1'b1, 16'hA003);
        @(posedge clk); #2;
        push1(0, 1'b1, 16'hB001);
        wait_idle(100);
        e4 = '{16'hA001, 16'hA002, 16'hA003, 16'hB001};
        chk("t3_count", out_log.size(), 4);
        for (int i = 0; i < 4 && i < out_log.size(); i++) chk("t3_order", out_log[i], e4[i]);
        chk("t3_prio_after", bus.Sel_SO, 0);

        // --- backpressure for 4 cycles
        clear_log();
        for (int i = 0; i < 6; i++) push0(0, 1'b1, 16'hC000 + 16'(i));
        repeat (3) @(posedge clk);
        #2 out_ready = 1'b0;
        held_data = bus.Out_DO;
        held_last = bus.OutLast_SO;
        chk("t4_stall_valid0", bus.OutValid_SO, 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            chk("t4_stall_data", bus.Out_DO, held_data);
            chk("t4_stall_last", bus.OutLast_SO, held_last);
            chk("t4_stall_valid", bus.OutValid_SO, 1);
            chk("t4_stall_ready0", bus.In0Ready_SO, 0);
        end
        out_ready = 1'b1;
        wait_idle(100);
        chk("t4_count", out_log.size(), 6);
        for (int i = 0; i < 6 && i < out_log.size(); i++) chk("t4_order", out_log[i], 16'hC000 + 16'(i));

        // --- gap inside a stream 1 packet (prio points to 1 after t4)
        clear_log();
        push1(0, 1'b0, 16'hD001);
        push1(3, 1'b1, 16'hD002);
        push0(0, 1'b1, 16'hE001);
        wait_idle(100);
        e3 = '{16'hD001, 16'hD002, 16'hE001};
        chk("t5_count", out_log.size(), 3);
        for (int i = 0; i < 3 && i < out_log.size(); i++) chk("t5_order", out_log[i], e3[i]);

        // --- reset while locked to stream 1
        clear_log();
        push1(0, 1'b0, 16'hF001);
        n = 0;
        while (out_log.size() < 1 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        chk("t6_lock_beat_seen", out_log.size(), 1);
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #2 rst = 1'b0;
        clear_log();
        push0(0, 1'b1, 16'h6000);
        push1(0, 1'b1, 16'h6111);
        wait_idle(100);
        chk("t6_count", out_log.size(), 2);
        if (out_log.size() >= 2) begin
            chk("t6_first", out_log[0], 16'h6000);
            chk("t6_second", out_log[1], 16'h6111);
        end

        // --- randomized traffic with random backpressure
        rand_mode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            push0($urandom_range(0, 3), (i == 149) || ($urandom_range(0, 2) == 0),
                  W'($urandom_range(0, 16'hFFFF)));
            push1($urandom_range(0, 3), (i == 149) || ($urandom_range(0, 2) == 0),
                  W'($urandom_range(0, 16'hFFFF)));
        end
        n = 0;
        while ((src0_q.size() != 0 || src1_q.size() != 0 || v[0] || v[1]) && n < 5000) begin
            @(posedge clk); #2;
            n++;
        end
        rand_mode = 1'b0;
        @(posedge clk); #2 out_ready = 1'b1;
        wait_idle(5000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux2_stream_arbiter.md
Name: mux2_stream_arbiter

Overview:
- Two-input round-robin stream arbiter with packet lock.
- Accepts two valid/ready data streams that carry end-of-packet markers.
- Generates the select for an internal MUX2 instance and registers the selected beat into a single output stage.
- Sits directly upstream of the downstream consumer and produces the select that steers the 2-input multiplexer.

Parameters:
WIDTH, 16, data width of each input stream and of the output.

Ports:
Clk_CI  input  1  clock, rising edge
Rst_RI  input  1  asynchronous reset, active-high
In0_DI  input  WIDTH  stream 0 data
In0Valid_SI  input  1  stream 0 beat valid
In0Last_SI  input  1  stream 0 last beat of packet
In0Ready_SO  output  1  stream 0 beat accepted this cycle when high together with In0Valid_SI
In1_DI  input  WIDTH  stream 1 data
In1Valid_SI  input  1  stream 1 beat valid
In1Last_SI  input  1  stream 1 last beat of packet
In1Ready_SO  output  1  stream 1 accept
Out_DO  output  WIDTH  registered output data
OutValid_SO  output  1  output beat valid
OutLast_SO  output  1  output last beat
OutReady_SI  input  1  downstream accept
Sel_SO  output  1  current grant (0 = stream 0, 1 = stream 1); combinational

Behaviour:
- Reset (asynchronous, active-high):
  - Registers: state IDLE, priority pointer Prio=0, OutValid_SO=0, OutLast_SO=0, Out_DO=0.
  - Sel_SO=0.
  - In0Ready_SO=In1Ready_SO=0 while Rst_RI is high.
- Output stage "free": Free = ~OutValid_SO | OutReady_SI.
- Grant (Sel_SO):
  - IDLE: if exactly one input is valid, grant it; if both are valid, grant Prio; if neither is valid, grant Prio.
  - LOCK0: grant 0. LOCK1: grant 1.
- Readies:
  - InxReady_SO = Free & (Sel_SO==x) & ~Rst_RI.
  - The non-granted input always sees ready=0.
- Beat acceptance: Acc = Free & valid of the granted input.
- On Acc:
  - Out_DO <= selected data (through MUX2).
  - OutLast_SO <= selected Last.
  - OutValid_SO <= 1.
- When Free and not Acc: OutValid_SO <= 0.
- When not Free: Out_DO, OutLast_SO and OutValid_SO hold.
- Latency: one cycle from the input handshake to OutValid_SO. Throughput is one beat per cycle with continuous OutReady_SI.
- State transitions, evaluated only on Acc:
  - IDLE, Last=1: stay IDLE, Prio <= ~Sel_SO.
  - IDLE, Last=0: go to LOCK[Sel_SO].
  - LOCKx, Last=1: go to IDLE, Prio <= ~x.
  - LOCKx, Last=0: stay LOCKx.
- Lock rule: while LOCKx, the other stream is never served, even if valid.
- Boundary conditions:
  - Single-beat packets (Last=1 on the first beat) never enter LOCK.
  - Simultaneous valid on both inputs in IDLE resolves by Prio, so single-beat traffic alternates 0,1,0,1.
  - An idle gap inside a locked packet keeps the lock; no timeout.
  - OutReady_SI low with OutValid_SO high freezes all outputs and state; the input readies drop to 0 in the same cycle.
  - Reset mid-packet returns to IDLE with Prio=0 and discards the output beat.
- Input protocol requirement, asserted by the bench and not checked in RTL: valid, data and Last are held stable until ready.
- Unknown state encodings decode as IDLE.

Decomposition:
- Package mux2_stream_arbiter_pkg:
  - State enum (IDLE, LOCK0, LOCK1), 2-bit encoding.
  - Constant GRANT_RESET=1'b0.
- Sub-module: one MUX2 instance (WIDTH passed through).
  - In0_DI/In1_DI connected to the stream data, Sel_SO to the select input.
  - Its output feeds the output data register.
- Last is muxed with the same select in the top level.

Test Plan:
- Reset check: assert Rst_RI asynchronously between clock edges with In0Valid_SI=1 -> OutValid_SO=0, Out_DO=0, Sel_SO=0, both readies 0 immediately; after release with In0Valid_SI=1, In0_DI=16'h00A5, Last=1 -> next cycle Out_DO=16'h00A5, OutValid_SO=1, OutLast_SO=1.
- Round-robin fairness: both inputs valid every cycle with Last=1, In0=16'h1111, In1=16'h2222, OutReady_SI=1 -> output alternates 1111, 2222, 1111, ... at one beat per cycle.
- Packet lock: In0 sends a 3-beat packet (Last on beat 3) while In1 is valid throughout -> In1Ready_SO stays 0 for 3 accepted beats; In1 beat appears immediately after, then Prio=0.
- Backpressure: OutReady_SI=0 for 4 cycles while holding OutValid_SO=1 -> Out_DO/OutLast_SO stable, both readies 0, no beat lost or duplicated after OutReady_SI returns to 1.
- Gap inside a packet: In1 beat 1 (Last=0), In1Valid_SI low 3 cycles while In0 is valid -> In0Ready_SO stays 0 until In1 Last beat accepted.
- Reset mid-packet: Rst_RI during LOCK1 -> after release, both valid with Last=1 -> stream 0 served first.
